ysyx_22050058_pipe_ctrl: RTL and testbench

Pipeline control block for the 5-stage core. It merges per-stage stall requests and control-flow redirects (EX branch/jump, MEM trap/return) into the 6-bit `stall` and `flush` vectors consumed by the PC register and every inter-stage register (if_id, id_ex, ex_mem, mem_wb). It also drives the PC redirect. When a redirect collides with an in-flight instruction fetch, a two-state FSM holds the target until the fetch returns and discards the stale instruction.

---
 rtl/ysyx_22050058_pipe_ctrl_pkg.sv | 44 ++++
 rtl/ysyx_22050058_pipe_ctrl.sv | 91 +++++++++
 tb/tb_ysyx_22050058_pipe_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050058_pipe_ctrl_pkg.sv
// Shared constants for the pipeline control block: stage indices, canonical
// stall/flush patterns, controller state encoding and the stall priority helper.
package ysyx_22050058_pipe_ctrl_pkg;

    localparam int INST_ADDR_W = 64;
    localparam int CTRL_W      = 6;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    localparam logic [CTRL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [CTRL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [CTRL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [CTRL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [CTRL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [CTRL_W-1:0] FLUSH_NONE = 6'b000000;
    localparam logic [CTRL_W-1:0] FLUSH_BR   = 6'b000110;
    localparam logic [CTRL_W-1:0] FLUSH_TRAP = 6'b011110;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_PEND = 1'b1
    } ctrl_state_t;

    // Deepest requester wins; the holds of all shallower registers are implied.
    function automatic logic [CTRL_W-1:0] stall_encode(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_if
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/ysyx_22050058_pipe_ctrl.sv
// Merges stage stall requests and EX/MEM redirects into stall/flush vectors and the PC redirect.
// Outputs are combinational (zero latency); a redirect blocked by an outstanding fetch is held in PEND.
module ysyx_22050058_pipe_ctrl
    import ysyx_22050058_pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   ex_redirect_i,
    input  logic [INST_ADDR_W-1:0] ex_target_i,
    input  logic                   mem_trap_i,
    input  logic [INST_ADDR_W-1:0] mem_trap_pc_i,
    output logic [CTRL_W-1:0]      stall,
    output logic [CTRL_W-1:0]      flush,
    output logic                   redirect_o,
    output logic [INST_ADDR_W-1:0] redirect_pc_o
);

    ctrl_state_t            state;
    ctrl_state_t            state_nxt;
    logic [INST_ADDR_W-1:0] pend_pc;
    logic [INST_ADDR_W-1:0] pend_pc_nxt;
    logic [INST_ADDR_W-1:0] target;
    logic                   trap_acc;
    logic                   br_acc;
    logic                   have_target;

    // The older trapping instruction beats a branch; while PEND the EX stage is wrong-path.
    assign trap_acc = mem_trap_i & ~stallreq_mem;
    assign br_acc   = ex_redirect_i & ~stallreq_mem & ~stallreq_ex & ~trap_acc
                    & (state == CTRL_IDLE);

    always_comb begin
        stall         = STALL_NONE;
        flush         = FLUSH_NONE;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        state_nxt     = state;
        pend_pc_nxt   = pend_pc;
        target        = '0;
        have_target   = 1'b0;

        if (!rst) begin
            stall = stall_encode(stallreq_mem, stallreq_ex, stallreq_id & ~br_acc, stallreq_if);

            if (trap_acc) begin
                flush       = FLUSH_TRAP;
                target      = mem_trap_pc_i;
                have_target = 1'b1;
            end else if (br_acc) begin
                flush       = FLUSH_BR;
                target      = ex_target_i;
                have_target = 1'b1;
            end

            // Pending redirect: keep dropping whatever IF delivers until the PC is reloaded.
            if (state == CTRL_PEND) begin
                flush[STAGE_IF] = 1'b1;
                if (!have_target) begin
                    target      = pend_pc;
                    have_target = 1'b1;
                end
            end

            if (have_target) begin
                if (stallreq_if) begin
                    pend_pc_nxt = target;
                    state_nxt   = CTRL_PEND;
                end else begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = target;
                    state_nxt     = CTRL_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CTRL_IDLE;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_pipe_ctrl.sv
// Bench for ysyx_22050058_pipe_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_ysyx_22050058_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sif, sid, sex, smem, exr, mt;
    logic [63:0] ext, mtpc;
    logic [5:0]  stall, flush;
    logic        redir;
    logic [63:0] rpc;

    int checks = 0;
    int passes = 0;

    // Reference state: is a redirect owed, and to where.
    bit          m_pend;
    logic [63:0] m_pc;

    logic [76:0] obs;
    assign obs = {stall, flush, redir, (redir ? rpc : 64'h0)};

    ysyx_22050058_pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (sif),
        .stallreq_id  (sid),
        .stallreq_ex  (sex),
        .stallreq_mem (smem),
        .ex_redirect_i(exr),
        .ex_target_i  (ext),
        .mem_trap_i   (mt),
        .mem_trap_pc_i(mtpc),
        .stall        (stall),
        .flush        (flush),
        .redirect_o   (redir),
        .redirect_pc_o(rpc)
    );

    always #5 clk = ~clk;

    function automatic void model(output logic [76:0] e, output bit np, output logic [63:0] npc);
        bit          trap, br, have;
        int          depth;
        logic [5:0]  s, f;
        logic [63:0] tgt;
        trap = mt && !smem;
        br   = !m_pend && exr && !smem && !sex && !trap;
        depth = smem ? 4 : sex ? 3 : (sid && !br) ? 2 : sif ? 1 : 0;
        s = (depth == 0) ? 6'd0 : 6'((1 << (depth + 1)) - 1);
        f = 6'd0;
        if (trap)   f = f | 6'b011110;
        if (br)     f = f | 6'b000110;
        if (m_pend) f = f | 6'b000010;
        tgt  = trap ? mtpc : br ? ext : m_pc;
        have = trap || br || m_pend;
        np   = have && sif;
        npc  = np ? tgt : m_pc;
        if (rst) begin
            e = '0; np = 1'b0; npc = '0;
        end else begin
            e = {s, f, (have && !sif), ((have && !sif) ? tgt : 64'h0)};
        end
    endfunction

    task automatic set_in(input bit i_if, input bit i_id, input bit i_ex, input bit i_mem,
                          input bit i_br, input logic [63:0] i_tgt,
                          input bit i_tr, input logic [63:0] i_tpc);
        sif = i_if; sid = i_id; sex = i_ex; smem = i_mem;
        exr = i_br; ext = i_tgt; mt = i_tr; mtpc = i_tpc;
        #1;
    endtask

    // Advance one edge, moving the model with the inputs that were applied this cycle.
    task automatic tick();
        logic [76:0] e;
        bit          np;
        logic [63:0] npc;
        model(e, np, npc);
        @(posedge clk);
        m_pend = np;
        m_pc   = npc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [76:0] e; bit np; logic [63:0] npc;
        rst = 1'b1;
        set_in(1, 1, 1, 1, 1, 64'h1234, 1, 64'h5678);
        checks++;
        if (obs !== 77'h0) $display("FAIL reset_outputs got=%h exp=0", obs);
        else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pend = 0; m_pc = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model(e, np, npc);
        checks++;
        if (obs !== e || obs !== 77'h0) $display("FAIL reset_idle got=%h exp=%h", obs, e);
        else passes++;
    endtask

    task automatic test_stall_priority();
        logic [76:0] e; bit np; logic [63:0] npc;
        set_in(0, 1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b011111 || flush !== 6'b000000 || redir !== 1'b0)
            $display("FAIL stall_mem_id got stall=%b flush=%b exp stall=011111 flush=000000", stall, flush);
        else passes++;
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b000111) $display("FAIL stall_id got=%b exp=000111", stall);
        else passes++;
        tick();
        set_in(1, 0, 1, 0, 0, 0, 0, 0);
        model(e, np, npc);
        checks++;
        if (obs !== e || stall !== 6'b001111) $display("FAIL stall_ex got=%h exp=%h", obs, e);
        else passes++;
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'b000011) $display("FAIL stall_if got=%b exp=000011", stall);
        else passes++;
        tick();
    endtask

    task automatic test_branch_idle();
        set_in(0, 1, 0, 0, 1, 64'h8000_0100, 0, 0);
        checks++;
        if (redir !== 1'b1 || rpc !== 64'h8000_0100 || flush !== 6'b000110 || stall !== 6'b000000)
            $display("FAIL branch_idle got redir=%b pc=%h flush=%b stall=%b exp 1/8000_0100/000110/000000",
                     redir, rpc, flush, stall);
        else passes++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (redir !== 1'b0 || flush !== 6'b0) $display("FAIL branch_idle_after got redir=%b flush=%b exp 0/000000", redir, flush);
        else passes++;
    endtask

    task automatic test_trap_priority();
        set_in(0, 0, 0, 0, 1, 64'h8000_0300, 1, 64'h8000_0004);
        checks++;
        if (redir !== 1'b1 || rpc !== 64'h8000_0004 || flush !== 6'b011110)
            $display("FAIL trap_over_branch got redir=%b pc=%h flush=%b exp 1/8000_0004/011110", redir, rpc, flush);
        else passes++;
        tick();
        // Trap held off by an LSU stall: nothing accepted.
        set_in(0, 0, 0, 1, 1, 64'h8000_0300, 1, 64'h8000_0004);
        checks++;
        if (redir !== 1'b0 || flush !== 6'b0 || stall !== 6'b011111)
            $display("FAIL trap_blocked got redir=%b flush=%b stall=%b exp 0/000000/011111", redir, flush, stall);
        else passes++;
        tick();
    endtask

    task automatic test_branch_pending();
        set_in(1, 0, 0, 0, 1, 64'h8000_0200, 0, 0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (redir !== 1'b0 || flush[1] !== 1'b1 || stall[1:0] !== 2'b11)
                $display("FAIL pend_hold cyc=%0d got redir=%b flush=%b stall=%b exp redir=0 flush[1]=1", c, redir, flush, stall);
            else passes++;
            tick();
            set_in(1, 0, 0, 0, 1, 64'h8000_0900, 0, 0);
        end
        set_in(0, 0, 0, 0, 1, 64'h8000_0900, 0, 0);
        checks++;
        if (redir !== 1'b1 || rpc !== 64'h8000_0200 || flush[1] !== 1'b1)
            $display("FAIL pend_release got redir=%b pc=%h flush=%b exp 1/8000_0200/flush[1]=1", redir, rpc, flush);
        else passes++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (redir !== 1'b0 || flush !== 6'b0) $display("FAIL pend_back_idle got redir=%b flush=%b exp 0/000000", redir, flush);
        else passes++;
    endtask

    task automatic test_trap_in_pend();
        set_in(1, 0, 0, 0, 1, 64'h8000_0200, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 64'h8000_0004);
        checks++;
        if (redir !== 1'b0 || flush !== 6'b011110)
            $display("FAIL pend_trap got redir=%b flush=%b exp 0/011110", redir, flush);
        else passes++;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (redir !== 1'b1 || rpc !== 64'h8000_0004)
            $display("FAIL pend_trap_release got redir=%b pc=%h exp 1/8000_0004", redir, rpc);
        else passes++;
        tick();
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 0, 1, 64'h8000_0200, 0, 0);
        tick();
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 77'h0) $display("FAIL async_reset got=%h exp=0", obs);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        m_pend = 0; m_pc = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (redir !== 1'b0 || flush !== 6'b0) $display("FAIL reset_drops_pend got redir=%b flush=%b exp 0/000000", redir, flush);
        else passes++;
        tick();
    endtask

    task automatic test_random();
        logic [76:0] e; bit np; logic [63:0] npc;
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(99) < 45), ($urandom_range(99) < 20), ($urandom_range(99) < 15),
                   ($urandom_range(99) < 15), ($urandom_range(99) < 30),
                   {32'h8000_0000, 20'h0, 10'($urandom), 2'b00},
                   ($urandom_range(99) < 12), {32'h8000_0000, 20'h1, 10'($urandom), 2'b00});
            if ($urandom_range(99) < 2) begin
                rst = 1'b1;
                #1;
            end
            model(e, np, npc);
            checks++;
            if (obs !== e) begin
                if (bad < 10) $display("FAIL random cyc=%0d got=%h exp=%h", n, obs, e);
                bad++;
            end else passes++;
            tick();
            if (rst) begin
                rst = 1'b0;
                m_pend = 0; m_pc = '0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        m_pend = 0; m_pc = '0;
        @(negedge clk);
        test_reset();
        test_stall_priority();
        test_branch_idle();
        test_trap_priority();
        test_branch_pending();
        test_trap_in_pend();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
